// File: rtl/amp_boot_loader.sv
// amp_boot_loader
// Streams the amp_cfg boot-memory bytes to the external amplifier over a
// 4-wire SPI master link (mode 0, MSB first). The last byte clocked in on
// MISO is returned to the register bank as the amplifier status.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   amp_cfg     {status[79:72], cfg[71:64], bootmem0[63:56] .. bootmem7[7:0]}
//   start       one-cycle request to run a boot transfer (IDLE only)
//   busy        high while the link is active (shift and hold phases)
//   done        one-cycle pulse when a transfer completes
//   status_out  last byte received on MISO, held until the next completion
//   status_we   write strobe for status_out, coincident with done
//   spi_cs_n    chip select, active low
//   spi_sclk    SPI clock, idles low
//   spi_mosi    serial data out, MSB first
//   spi_miso    serial data in, already synchronised
//
// CLK_DIV is the SCLK half-period in clk cycles (1..255).
module amp_boot_loader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] amp_cfg,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  status_out,
  output logic        status_we,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div;       // cycles elapsed in the current half-period
  logic        r_high;      // 1 while in the high half of a bit
  logic [6:0]  r_bit_cnt;   // bits completed in this transfer
  logic [5:0]  r_last_bit;  // index of the final bit, 8*N-1
  logic [63:0] r_tx;
  logic [7:0]  r_rx;
  logic        w_div_end;
  logic        w_last_bit;
  logic        w_active;
  logic        w_unused;

  // The stored status byte and the upper cfg bits play no part in the transfer.
  assign w_unused   = ^amp_cfg[79:67];

  assign w_div_end  = (r_div == DIV_LAST);
  assign w_last_bit = (r_bit_cnt == {1'b0, r_last_bit});
  assign w_active   = (w_next == S_SHIFT) || (w_next == S_HOLD);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SHIFT;
      S_SHIFT: if (w_div_end && r_high && w_last_bit) w_next = S_HOLD;
      S_HOLD:  if (w_div_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe and no input reaches an output combinationally.
  // NOTE: the shift registers are plain flops, so they are reset with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      status_we  <= 1'b0;
      status_out <= 8'h00;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      r_div      <= 8'd0;
      r_high     <= 1'b0;
      r_bit_cnt  <= 7'd0;
      r_last_bit <= 6'd0;
      r_tx       <= 64'd0;
      r_rx       <= 8'd0;
    end else begin
      busy      <= w_active;
      spi_cs_n  <= !w_active;
      done      <= (w_next == S_DONE);
      status_we <= (w_next == S_DONE);
      if (w_next == S_DONE) status_out <= r_rx;

      case (r_state)
        S_IDLE: begin
          r_div     <= 8'd0;
          r_high    <= 1'b0;
          r_bit_cnt <= 7'd0;
          spi_sclk  <= 1'b0;
          if (start) begin
            // Snapshot so register-bank writes cannot disturb the transfer.
            r_tx       <= amp_cfg[63:0];
            r_last_bit <= {amp_cfg[66:64], 3'b111};
            spi_mosi   <= amp_cfg[63];
          end
        end
        S_SHIFT: begin
          if (w_div_end) begin
            r_div <= 8'd0;
            if (!r_high) begin
              // Rising edge of SCLK: capture MISO.
              r_high   <= 1'b1;
              spi_sclk <= 1'b1;
              r_rx     <= {r_rx[6:0], spi_miso};
            end else begin
              // Falling edge of SCLK: advance to the next bit.
              r_high    <= 1'b0;
              spi_sclk  <= 1'b0;
              r_tx      <= {r_tx[62:0], 1'b0};
              spi_mosi  <= r_tx[62];
              r_bit_cnt <= r_bit_cnt + 7'd1;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_HOLD: begin
          if (w_div_end) r_div <= 8'd0;
          else           r_div <= r_div + 8'd1;
        end
        default: begin
          r_div <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amp_boot_loader.sv
// Testbench for amp_boot_loader. Two instances (CLK_DIV=2 and CLK_DIV=1)
// share clock, reset and amp_cfg. Stimulus pushes the expected transfer
// result into a scoreboard queue; a monitor decodes MOSI on SCLK rises,
// counts chip-select low cycles, models MISO and checks each done pulse.
module tb_amp_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [79:0] amp_cfg;
  logic [1:0]  start_v;
  logic [1:0]  busy_v, done_v, we_v, cs_v, sclk_v, mosi_v, miso_v;
  logic [7:0]  stat_v [2];
  logic [63:0] miso_pat [2];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [2];

  typedef struct {
    int          inst;
    int          bits;
    logic [63:0] mosi;
    int          cs_cycles;
    logic [7:0]  status;
  } exp_t;

  exp_t sb_q[$];

  // MISO model: bit k of a transfer is miso_pat[63-k].
  int          rise_cnt [2];
  int          cs_cnt   [2];
  logic [63:0] mosi_acc [2];
  logic [1:0]  prev_sclk;
  exp_t        mon_e;

  assign miso_v[0] = miso_pat[0][6'd63 - 6'(rise_cnt[0])];
  assign miso_v[1] = miso_pat[1][6'd63 - 6'(rise_cnt[1])];

  amp_boot_loader #(.CLK_DIV(2)) u_dut_div2 (
    .clk(clk), .rst(rst), .amp_cfg(amp_cfg), .start(start_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .status_out(stat_v[0]),
    .status_we(we_v[0]), .spi_cs_n(cs_v[0]), .spi_sclk(sclk_v[0]),
    .spi_mosi(mosi_v[0]), .spi_miso(miso_v[0])
  );

  amp_boot_loader #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .amp_cfg(amp_cfg), .start(start_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .status_out(stat_v[1]),
    .status_we(we_v[1]), .spi_cs_n(cs_v[1]), .spi_sclk(sclk_v[1]),
    .spi_mosi(mosi_v[1]), .spi_miso(miso_v[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] out_vec(input int i);
    return {busy_v[i], done_v[i], we_v[i], stat_v[i], cs_v[i], sclk_v[i], mosi_v[i]};
  endfunction

  localparam logic [13:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

  // Monitor / scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rise_cnt[i]  = 0;
        cs_cnt[i]    = 0;
        mosi_acc[i]  = 64'd0;
        prev_sclk[i] = 1'b0;
      end else begin
        if (!cs_v[i]) cs_cnt[i]++;
        if (sclk_v[i] && !prev_sclk[i]) begin
          mosi_acc[i] = {mosi_acc[i][62:0], mosi_v[i]};
          rise_cnt[i]++;
        end
        prev_sclk[i] = sclk_v[i];
        if (done_v[i]) begin
          done_cnt[i]++;
          if (sb_q.size() == 0 || sb_q[0].inst != i) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done inst%0d: got done=1 expected no done", i);
          end else begin
            mon_e = sb_q.pop_front();
            check($sformatf("status_out inst%0d", i), 64'(stat_v[i]), 64'(mon_e.status));
            check($sformatf("status_we inst%0d", i), 64'(we_v[i]), 64'd1);
            check($sformatf("busy_at_done inst%0d", i), 64'(busy_v[i]), 64'd0);
            check($sformatf("sclk_rises inst%0d", i), 64'(rise_cnt[i]), 64'(mon_e.bits));
            check($sformatf("mosi_data inst%0d", i), mosi_acc[i], mon_e.mosi);
            check($sformatf("cs_low_cycles inst%0d", i), 64'(cs_cnt[i]), 64'(mon_e.cs_cycles));
          end
          rise_cnt[i] = 0;
          cs_cnt[i]   = 0;
          mosi_acc[i] = 64'd0;
        end
      end
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int base;
    int n;
    base = done_cnt[i];
    n = 0;
    while (done_cnt[i] == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt[i] == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout inst%0d: got no done within %0d cycles", i, budget);
    end
  endtask

  task automatic push_exp(input int i, input int bits, input logic [63:0] mosi,
                          input int cs_cycles, input logic [7:0] status);
    exp_t e;
    e.inst = i; e.bits = bits; e.mosi = mosi; e.cs_cycles = cs_cycles; e.status = status;
    sb_q.push_back(e);
  endtask

  task automatic run(input int i, input logic [79:0] cfg, input logic [63:0] pat,
                     input int bits, input logic [63:0] mosi, input int cs_cycles,
                     input logic [7:0] status);
    amp_cfg     = cfg;
    miso_pat[i] = pat;
    push_exp(i, bits, mosi, cs_cycles, status);
    pulse_start(i);
    wait_done(i, 400);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst         = 1'b1;
    start_v     = 2'b00;
    amp_cfg     = 80'd0;
    miso_pat[0] = 64'd0;
    miso_pat[1] = 64'd0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs inst0", 64'(out_vec(0)), 64'(RESET_VEC));
    check("reset_outputs inst1", 64'(out_vec(1)), 64'(RESET_VEC));
    rst = 1'b0;

    // One byte, CLK_DIV=2: 2*2*8+2 = 34 cycles of chip select.
    run(0, {8'h00, 8'h00, 64'hA5FF_FFFF_FFFF_FFFF}, 64'h3C00_0000_0000_0000,
        8, 64'hA5, 34, 8'h3C);

    // Eight bytes, CLK_DIV=1: 2*1*64+1 = 129 cycles.
    run(1, {8'h00, 8'h07, 64'h0102_0304_0506_0708}, 64'h1122_3344_5566_7788,
        64, 64'h0102_0304_0506_0708, 129, 8'h88);

    // cfg=0xFA -> N=3, 24 bits; 2*2*24+2 = 98 cycles.
    run(0, {8'h00, 8'hFA, 64'hDEAD_BEEF_0011_2233}, 64'hC35A_96FF_0000_0000,
        24, 64'hDEADBE, 98, 8'h96);

    // Snapshot and ignored second start while busy.
    base        = done_cnt[0];
    amp_cfg     = {8'h00, 8'h01, 64'h1234_5678_9ABC_DEF0};
    miso_pat[0] = 64'h0FF0_0000_0000_0000;
    push_exp(0, 16, 64'h1234, 66, 8'hF0);
    pulse_start(0);
    repeat (10) @(negedge clk);
    amp_cfg[63:56] = 8'hFF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (80) @(negedge clk);
    check("single_done_after_restart_attempt", 64'(done_cnt[0]), 64'(base + 1));

    // Reset during bit 13 (bit 5 of byte 1).
    base        = done_cnt[0];
    amp_cfg     = {8'h00, 8'h01, 64'h5AC3_0000_0000_0000};
    miso_pat[0] = 64'h8001_0000_0000_0000;
    pulse_start(0);
    repeat (53) @(negedge clk);
    check("busy_before_reset", 64'(busy_v[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("outputs_after_midreset", 64'(out_vec(0)), 64'(RESET_VEC));
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt[0]), 64'(base));
    run(0, {8'h00, 8'h01, 64'h5AC3_0000_0000_0000}, 64'h8001_0000_0000_0000,
        16, 64'h5AC3, 66, 8'h01);

    // Back-to-back: start in DONE ignored, start one cycle later accepted.
    amp_cfg     = {8'h00, 8'h00, 64'h9600_0000_0000_0000};
    miso_pat[1] = 64'h6900_0000_0000_0000;
    push_exp(1, 8, 64'h96, 17, 8'h69);
    pulse_start(1);
    n = 0;
    while (!done_v[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done_seen", 64'(done_v[1]), 64'd1);
    start_v[1] = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 64'({busy_v[1], cs_v[1]}), 64'(2'b01));
    push_exp(1, 8, 64'h96, 17, 8'h69);
    @(negedge clk);
    start_v[1] = 1'b0;
    check("b2b_cs_low", 64'({busy_v[1], cs_v[1]}), 64'(2'b10));
    wait_done(1, 100);
    repeat (10) @(negedge clk);

    check("total_done inst0", 64'(done_cnt[0]), 64'd4);
    check("total_done inst1", 64'(done_cnt[1]), 64'd3);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
